// File: rtl/reflet_float_mult_seq_mnt.sv
// Iterative shift-and-add unsigned mantissa multiplier with a start/ready handshake.
// Define REFLET_FLOAT_MULT_RADIX4_EN to retire two multiplier bits per cycle instead of one.
module reflet_float_mult_seq_mnt #(
  parameter int size = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [size-1:0]   in1,
  input  logic [size-1:0]   in2,
  output logic              busy,
  output logic              ready,
  output logic [2*size-1:0] product
);

  localparam int PW = 2 * size;
`ifdef REFLET_FLOAT_MULT_RADIX4_EN
  localparam int STEPS = (size + 1) / 2;
  localparam int BW    = 2 * STEPS;   // odd widths gain one zero bit on top
`else
  localparam int STEPS = size;
  localparam int BW    = size;
`endif
  localparam int CW = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   acc, acc_next, term;
  logic [PW-1:0]   a_sh;               // multiplicand pre-shifted to the current bit weight
  logic [BW-1:0]   b;
  logic [CW-1:0]   count;
`ifdef REFLET_FLOAT_MULT_RADIX4_EN
  logic [PW-1:0]   a3_sh;              // 3*a at the current weight, formed once on start
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = RUN;
      RUN:        if (count == LAST) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  assign busy  = (state == RUN);
  assign ready = (state == DONE);

  always_comb begin
    term = '0;
`ifdef REFLET_FLOAT_MULT_RADIX4_EN
    case (b[1:0])
      2'd1:    term = a_sh;
      2'd2:    term = a_sh << 1;
      2'd3:    term = a3_sh;
      default: term = '0;
    endcase
`else
    if (b[0]) term = a_sh;
`endif
    acc_next = acc + term;
  end

  // NOTE: datapath registers are few and narrow-purpose, so all of them are
  // cleared on reset; an aborted operation then leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      a_sh    <= '0;
      b       <= '0;
      count   <= '0;
      product <= '0;
`ifdef REFLET_FLOAT_MULT_RADIX4_EN
      a3_sh   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc   <= '0;
            a_sh  <= PW'(in1);
            b     <= BW'(in2);
            count <= '0;
`ifdef REFLET_FLOAT_MULT_RADIX4_EN
            a3_sh <= PW'(in1) + (PW'(in1) << 1);
`endif
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + CW'(1);
`ifdef REFLET_FLOAT_MULT_RADIX4_EN
          a_sh  <= a_sh << 2;
          a3_sh <= a3_sh << 2;
          b     <= b >> 2;
`else
          a_sh  <= a_sh << 1;
          b     <= b >> 1;
`endif
          // product only moves on entry to DONE; the consumer never sees partial sums
          if (count == LAST) product <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_float_mult_seq_mnt.sv
// Directed self-checking bench: a size=24 instance and an odd size=5 instance.
// Expected latencies follow REFLET_FLOAT_MULT_RADIX4_EN when defined.
module tb_reflet_float_mult_seq_mnt;

`ifdef REFLET_FLOAT_MULT_RADIX4_EN
  localparam int STEPS24 = 12;
  localparam int STEPS5  = 3;
`else
  localparam int STEPS24 = 24;
  localparam int STEPS5  = 5;
`endif

  logic        clk, reset;
  logic        start, busy, ready;
  logic [23:0] in1, in2;
  logic [47:0] product;
  logic        start5, busy5, ready5;
  logic [4:0]  in1_5, in2_5;
  logic [9:0]  product5;

  int checks = 0;
  int errors = 0;

  reflet_float_mult_seq_mnt #(.size(24)) dut (
    .clk(clk), .reset(reset), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .ready(ready), .product(product)
  );

  reflet_float_mult_seq_mnt #(.size(5)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .in1(in1_5), .in2(in2_5),
    .busy(busy5), .ready(ready5), .product(product5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns cycles until ready, RUN cycles, and ready/product one cycle in.
  task automatic launch(input logic [23:0] x, input logic [23:0] y, output int lat,
                        output int bcnt, output logic rdy1, output logic [47:0] prod1);
    in1 = x; in2 = y; start = 1'b1; lat = 0; bcnt = 0;
    @(negedge clk);
    start = 1'b0; in1 = ~x; in2 = ~y;
    lat = 1; rdy1 = ready; prod1 = product;
    if (busy) bcnt++;
    while (!ready && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; start5 = 1'b0;
    in1 = '0; in2 = '0; in1_5 = '0; in2_5 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, ready, product} !== 50'd0) begin
      errors++;
      $display("FAIL reset_hold: busy=%b ready=%b product=%h, required 0 0 0", busy, ready, product);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, ready, product, busy5, ready5, product5} !== 62'd0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: busy=%b ready=%b product=%h busy5=%b ready5=%b product5=%h, required all 0",
                 i, busy, ready, product, busy5, ready5, product5);
      end
    end
  endtask

  task automatic test_full_scale();
    int lat, bcnt; logic rdy1; logic [47:0] p1;
    launch(24'hFFFFFF, 24'hFFFFFF, lat, bcnt, rdy1, p1);
    checks++;
    if (lat !== STEPS24 + 1) begin
      errors++; $display("FAIL full_latency: got %0d cycles, required %0d", lat, STEPS24 + 1);
    end
    checks++;
    if (bcnt !== STEPS24) begin
      errors++; $display("FAIL full_busy: busy for %0d cycles, required %0d", bcnt, STEPS24);
    end
    checks++;
    if (product !== 48'hFFFFFE000001) begin
      errors++; $display("FAIL full_product: got %h, required fffffe000001", product);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!(ready === 1'b1 && busy === 1'b0 && product === 48'hFFFFFE000001)) begin
      errors++; $display("FAIL done_hold: ready=%b busy=%b product=%h, required 1 0 fffffe000001", ready, busy, product);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; logic rdy1; logic [47:0] p1;
    launch(24'h800000, 24'hC00000, lat, bcnt, rdy1, p1);
    checks++;
    if (product !== 48'h600000000000 || lat !== STEPS24 + 1) begin
      errors++; $display("FAIL b2b_first: product=%h lat=%0d, required 600000000000 lat=%0d", product, lat, STEPS24 + 1);
    end
    launch(24'h000000, 24'hABCDEF, lat, bcnt, rdy1, p1);
    checks++;
    if (rdy1 !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_drop: ready=%b one cycle after start, required 0", rdy1);
    end
    checks++;
    if (p1 !== 48'h600000000000) begin
      errors++; $display("FAIL b2b_product_hold: product=%h during RUN, required 600000000000", p1);
    end
    checks++;
    if (product !== 48'h0 || lat !== STEPS24 + 1) begin
      errors++; $display("FAIL b2b_zero: product=%h lat=%0d, required 0 lat=%0d", product, lat, STEPS24 + 1);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    in1 = 24'h000003; in2 = 24'h000005; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    in1 = 24'hFFFFFF; in2 = 24'hFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat++;
    while (!ready && lat < 200) begin @(negedge clk); lat++; end
    checks++;
    if (product !== 48'h00000000000F || lat !== STEPS24 + 1) begin
      errors++; $display("FAIL start_in_run: product=%h lat=%0d, required f lat=%0d", product, lat, STEPS24 + 1);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt; logic rdy1; logic [47:0] p1;
    in1 = 24'hFFFFFF; in2 = 24'hFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, ready, product} !== 50'd0) begin
      errors++; $display("FAIL async_reset: busy=%b ready=%b product=%h, required 0 0 0", busy, ready, product);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, ready, product} !== 50'd0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b ready=%b product=%h, required 0 0 0", busy, ready, product);
    end
    launch(24'h000002, 24'h000007, lat, bcnt, rdy1, p1);
    checks++;
    if (product !== 48'h00000000000E || lat !== STEPS24 + 1) begin
      errors++; $display("FAIL after_abort: product=%h lat=%0d, required e lat=%0d", product, lat, STEPS24 + 1);
    end
  endtask

  task automatic test_small_vectors();
    logic [23:0] va [3] = '{24'h000001, 24'hABCDEF, 24'h000100};
    logic [23:0] vb [3] = '{24'h000001, 24'h000000, 24'h000100};
    logic [47:0] ve [3] = '{48'h1, 48'h0, 48'h10000};
    int lat, bcnt; logic rdy1; logic [47:0] p1;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], lat, bcnt, rdy1, p1);
      checks++;
      if (product !== ve[i] || lat !== STEPS24 + 1) begin
        errors++; $display("FAIL vec[%0d]: product=%h lat=%0d, required %h lat=%0d", i, product, lat, ve[i], STEPS24 + 1);
      end
    end
  endtask

  task automatic test_odd_width();
    logic [4:0] va [3] = '{5'h1F, 5'h1F, 5'h10};
    logic [4:0] vb [3] = '{5'h1F, 5'h01, 5'h11};
    logic [9:0] ve [3] = '{10'h3C1, 10'h01F, 10'h110};
    int lat;
    for (int i = 0; i < 3; i++) begin
      in1_5 = va[i]; in2_5 = vb[i]; start5 = 1'b1;
      @(negedge clk);
      start5 = 1'b0; in1_5 = ~va[i]; in2_5 = ~vb[i]; lat = 1;
      while (!ready5 && lat < 50) begin @(negedge clk); lat++; end
      checks++;
      if (product5 !== ve[i] || lat !== STEPS5 + 1) begin
        errors++; $display("FAIL odd[%0d]: product=%h lat=%0d, required %h lat=%0d", i, product5, lat, ve[i], STEPS5 + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_small_vectors();
    test_odd_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
